axis_frame_receiver: RTL and testbench

- AXI4-Stream video frame sink: the receiving end for raster pixel streams.
- Consumes a raster stream framed by TUSER (start of frame) and TLAST (end of frame) for an H_RES x V_RES frame.
- Recovers pixel coordinates (x, y) and forwards each pixel through a registered valid/ready output stage.
- Checks frame structure, reports framing errors and counts good and bad frames; used at the far end of video pipelines and as a checker in benches.

---
 rtl/axis_frame_receiver.sv | 174 +++++++++++++++++
 tb/tb_axis_frame_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_receiver.sv
// AXI4-Stream video frame sink: recovers raster coordinates, forwards pixels
// through one registered valid/ready slice and checks SOF/EOF framing.
module axis_frame_receiver #(
  parameter int H_RES      = 1024,
  parameter int V_RES      = 768,
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int CounterWidthX = $clog2(H_RES),
  localparam int CounterWidthY = $clog2(V_RES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
  input  logic                     s_axis_tlast_i,
  output logic                     pix_valid_o,
  input  logic                     pix_ready_i,
  output logic [DATA_WIDTH-1:0]    pix_data_o,
  output logic [CounterWidthX-1:0] x_o,
  output logic [CounterWidthY-1:0] y_o,
  output logic                     sof_o,
  output logic                     eof_o,
  output logic                     frame_done_o,
  output logic                     frame_err_o,
  output logic [1:0]               err_code_o,
  output logic [CNT_WIDTH-1:0]     frame_cnt_o,
  output logic [CNT_WIDTH-1:0]     err_cnt_o
);

  typedef enum logic { ST_WAIT_SOF, ST_IN_FRAME } state_t;
  typedef enum logic [1:0] {
    ERR_NONE, ERR_EARLY_SOF, ERR_EARLY_LAST, ERR_MISSING_LAST
  } err_t;

  localparam logic [CounterWidthX-1:0] X_LAST = CounterWidthX'(H_RES - 1);
  localparam logic [CounterWidthY-1:0] Y_LAST = CounterWidthY'(V_RES - 1);

  state_t                   r_state, w_state_next;
  logic [CounterWidthX-1:0] r_x, w_x_next, w_out_x;
  logic [CounterWidthY-1:0] r_y, w_y_next, w_out_y;
  logic                     w_accept, w_tuser, w_at_last;
  logic                     w_emit, w_sof, w_eof, w_done, w_err;
  err_t                     w_code;

  logic                     r_valid, r_sof, r_eof, r_done, r_err;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [CounterWidthX-1:0] r_out_x;
  logic [CounterWidthY-1:0] r_out_y;
  err_t                     r_code;
  logic [CNT_WIDTH-1:0]     r_frame_cnt, r_err_cnt;

  // The slice may take a new beat when empty or draining; never during reset.
  assign s_axis_tready_o = !rst_i && (!r_valid || pix_ready_i);
  assign w_accept        = s_axis_tvalid_i && s_axis_tready_o;
  assign w_tuser         = s_axis_tuser_i[0];
  assign w_at_last       = (r_x == X_LAST) && (r_y == Y_LAST);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_out_x      = r_x;
    w_out_y      = r_y;
    w_emit       = 1'b0;
    w_sof        = 1'b0;
    w_eof        = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_code       = ERR_NONE;
    if (w_accept) begin
      if (w_tuser) begin
        // A start of frame always restarts at (0,0); inside a frame it is also an error.
        w_emit       = 1'b1;
        w_sof        = 1'b1;
        w_out_x      = '0;
        w_out_y      = '0;
        w_x_next     = CounterWidthX'(1);
        w_y_next     = '0;
        w_state_next = ST_IN_FRAME;
        if (r_state == ST_IN_FRAME) begin
          w_err  = 1'b1;
          w_code = ERR_EARLY_SOF;
        end
      end else if (r_state == ST_IN_FRAME) begin
        w_emit = 1'b1;
        if (s_axis_tlast_i && !w_at_last) begin
          w_err        = 1'b1;
          w_code       = ERR_EARLY_LAST;
          w_state_next = ST_WAIT_SOF;
        end else if (w_at_last && !s_axis_tlast_i) begin
          w_err        = 1'b1;
          w_code       = ERR_MISSING_LAST;
          w_state_next = ST_WAIT_SOF;
        end else if (w_at_last) begin
          w_eof        = 1'b1;
          w_done       = 1'b1;
          w_state_next = ST_WAIT_SOF;
        end else if (r_x == X_LAST) begin
          w_x_next = '0;
          w_y_next = r_y + CounterWidthY'(1);
        end else begin
          w_x_next = r_x + CounterWidthX'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_WAIT_SOF;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= ERR_NONE;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      // Pulses follow acceptance only, so a stalled pixel never re-reports.
      r_done <= w_done;
      r_err  <= w_err;
      if (w_accept) begin
        r_valid <= w_emit;
        r_data  <= s_axis_tdata_i;
        r_out_x <= w_out_x;
        r_out_y <= w_out_y;
        r_sof   <= w_sof;
        r_eof   <= w_eof;
      end else if (pix_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_err) begin
        r_code    <= w_code;
        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
      end
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign pix_valid_o  = r_valid;
  assign pix_data_o   = r_data;
  assign x_o          = r_out_x;
  assign y_o          = r_out_y;
  assign sof_o        = r_sof;
  assign eof_o        = r_eof;
  assign frame_done_o = r_done;
  assign frame_err_o  = r_err;
  assign err_code_o   = r_code;
  assign frame_cnt_o  = r_frame_cnt;
  assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_axis_frame_receiver.sv
// Directed bench for axis_frame_receiver on a 4x3 raster: clean frames,
// dropped pre-SOF beats, each framing error, output stalls and mid-frame reset.
module tb_axis_frame_receiver;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata = '0;
  logic [0:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [15:0] pix_data;
  logic [1:0]  pix_x, pix_y;
  logic        sof, eof, fdone, ferr;
  logic [1:0]  ecode;
  logic [15:0] fcnt, ecnt;

  int          checks = 0;
  int          failures = 0;
  int          done_pulses = 0;
  int          err_pulses = 0;
  bit          stall_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [21:0] prev_pix = '0;
  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  axis_frame_receiver #(
    .H_RES(H), .V_RES(V), .DATA_WIDTH(16), .USER_WIDTH(1), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
    .s_axis_tdata_i(s_tdata), .s_axis_tuser_i(s_tuser), .s_axis_tlast_i(s_tlast),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_data_o(pix_data),
    .x_o(pix_x), .y_o(pix_y), .sof_o(sof), .eof_o(eof),
    .frame_done_o(fdone), .frame_err_o(ferr), .err_code_o(ecode),
    .frame_cnt_o(fcnt), .err_cnt_o(ecnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: collects transfers, counts pulses, checks hold-while-stalled.
  always @(negedge clk) begin
    logic [21:0] cur;
    cur = {pix_data, pix_x, pix_y, sof, eof};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(pix_valid), 32'd1);
        check("stall_stable", 32'(cur), 32'(prev_pix));
      end
      if (pix_valid && pix_ready) got_q.push_back(cur);
      if (fdone) done_pulses++;
      if (ferr) err_pulses++;
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur;
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_en) pix_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = 1'b0; s_tuser = '0; s_tlast = 1'b0; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete(); exp_q.delete();
    done_pulses = 0; err_pulses = 0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
    logic acc;
    int   n;
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      n++;
    end
    check("beat_accepted", 32'(acc), 32'd1);
  endtask

  function automatic void exp_pix(input int d, input int x, input int y, input bit s, input bit e);
    exp_q.push_back({16'(d), 2'(x), 2'(y), s, e});
  endfunction

  task automatic send_frame(input int base);
    for (int i = 0; i < H * V; i++) begin
      send_beat(16'(base + i), i == 0, i == H * V - 1);
      exp_pix(base + i, i % H, i / H, i == 0, i == H * V - 1);
    end
  endtask

  task automatic compare_pixels(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    // Reset state, with TVALID already high to show TREADY is held low.
    s_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_flags", 32'({sof, eof, fdone, ferr}), 32'd0);
    check("rst_code", 32'(ecode), 32'd0);
    check("rst_fcnt", 32'(fcnt), 32'd0);
    check("rst_ecnt", 32'(ecnt), 32'd0);

    // Clean frame.
    do_reset();
    send_frame(16'h0100);
    idle(5);
    compare_pixels("clean");
    check("clean_done", 32'(done_pulses), 32'd1);
    check("clean_fcnt", 32'(fcnt), 32'd1);
    check("clean_ecnt", 32'(ecnt), 32'd0);

    // Three pre-SOF beats are dropped.
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(16'(16'h0A00 + i), 1'b0, 1'b0);
    send_frame(16'h0200);
    idle(5);
    compare_pixels("drop");
    check("drop_err", 32'(err_pulses), 32'd0);
    check("drop_fcnt", 32'(fcnt), 32'd1);

    // TLAST on beat 6 at (1,1), then a clean frame.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_beat(16'(16'h0300 + i), i == 0, i == 5);
      exp_pix(16'h0300 + i, i % H, i / H, i == 0, 1'b0);
    end
    idle(5);
    compare_pixels("elast");
    check("elast_pulse", 32'(err_pulses), 32'd1);
    check("elast_code", 32'(ecode), 32'd2);
    check("elast_ecnt", 32'(ecnt), 32'd1);
    check("elast_done", 32'(done_pulses), 32'd0);
    send_frame(16'h0380);
    idle(5);
    check("elast_fcnt", 32'(fcnt), 32'd1);
    check("elast_ecnt2", 32'(ecnt), 32'd1);
    check("elast_code_held", 32'(ecode), 32'd2);

    // TUSER on beat 5 restarts the frame.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_beat(16'(16'h0400 + i), i == 0, 1'b0);
      exp_pix(16'h0400 + i, i, 0, i == 0, 1'b0);
    end
    for (int j = 0; j < H * V; j++) begin
      send_beat(16'(16'h0480 + j), j == 0, j == H * V - 1);
      exp_pix(16'h0480 + j, j % H, j / H, j == 0, j == H * V - 1);
    end
    idle(5);
    compare_pixels("esof");
    check("esof_code", 32'(ecode), 32'd1);
    check("esof_pulse", 32'(err_pulses), 32'd1);
    check("esof_done", 32'(done_pulses), 32'd1);
    check("esof_fcnt", 32'(fcnt), 32'd1);

    // Missing TLAST on beat 12; beat 13 without TUSER is dropped.
    do_reset();
    for (int i = 0; i < H * V; i++) begin
      send_beat(16'(16'h0500 + i), i == 0, 1'b0);
      exp_pix(16'h0500 + i, i % H, i / H, i == 0, 1'b0);
    end
    send_beat(16'h05FF, 1'b0, 1'b0);
    idle(5);
    compare_pixels("mlast");
    check("mlast_code", 32'(ecode), 32'd3);
    check("mlast_ecnt", 32'(ecnt), 32'd1);
    check("mlast_pulse", 32'(err_pulses), 32'd1);
    check("mlast_fcnt", 32'(fcnt), 32'd0);

    // Random output stalls.
    do_reset();
    stall_en = 1'b1;
    send_frame(16'h0700);
    idle(40);
    stall_en = 1'b0;
    #1;
    pix_ready = 1'b1;
    idle(5);
    compare_pixels("stall");
    check("stall_fcnt", 32'(fcnt), 32'd1);
    check("stall_done", 32'(done_pulses), 32'd1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) send_beat(16'(16'h0800 + i), i == 0, 1'b0);
    check("mid_pre_valid", 32'(pix_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(pix_valid), 32'd0);
    check("mid_tready", 32'(s_tready), 32'd0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    check("mid_ecnt", 32'(ecnt), 32'd0);
    check("mid_code", 32'(ecode), 32'd0);
    check("mid_err_pulse", 32'(err_pulses), 32'd0);
    check("mid_fcnt", 32'(fcnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
